// File: rtl/circle_octant_draw.sv
// circle_octant_draw
//   Midpoint (Bresenham) circle rasteriser driving the vga_adapter plot port.
//   Each iteration walks the eight octant reflections of (ox, oy), one per
//   cycle, then spends one cycle on the midpoint update. A per-octant mask
//   selects which reflections are plotted; every pixel is clipped to the
//   SCREEN_W x SCREEN_H visible area.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   start        draw request, held by the requester until done is seen
//   centre_x/y   circle centre, latched on start
//   radius       radius in pixels (0 plots the centre only), latched on start
//   colour       pixel colour, latched on start
//   octant_mask  bit k enables octant k, latched on start
//   done         high while in END_DRAW
//   vga_x/vga_y  current candidate pixel (low bits of the signed coordinate)
//   vga_colour   latched colour
//   vga_plot     write strobe for the current pixel
module circle_octant_draw #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [X_W-1:0]   centre_x,
  input  logic [Y_W-1:0]   centre_y,
  input  logic [R_W-1:0]   radius,
  input  logic [COL_W-1:0] colour,
  input  logic [7:0]       octant_mask,
  output logic             done,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot
);

  localparam int XY_MAX = (X_W > Y_W) ? X_W : Y_W;
  localparam int C_MAX  = (XY_MAX > R_W) ? XY_MAX : R_W;
  localparam int CW     = C_MAX + 2;  // signed coordinate width, never wraps
  localparam int CRW    = R_W + 3;    // signed decision-variable width

  localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DRAW     = 2'b01,
    UPDATE   = 2'b10,
    END_DRAW = 2'b11
  } state_t;

  state_t                  state, state_d;
  logic [2:0]              k_q, k_d;
  logic signed [CW-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic signed [CRW-1:0]   crit_q, crit_d;
  logic [X_W-1:0]          cx_q, cx_d;
  logic [Y_W-1:0]          cy_q, cy_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [7:0]              mask_q, mask_d;

  logic signed [CW-1:0]    oy_n, ox_n, dif;
  logic signed [CW-1:0]    sx, sy, cand_x, cand_y;
  logic                    on_screen, plot_d;

  // Next-state and datapath update
  always_comb begin
    state_d = state;
    k_d     = k_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    mask_d  = mask_q;
    oy_n    = oy_q + CW'(1);
    ox_n    = ox_q;
    dif     = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          col_d   = colour;
          mask_d  = octant_mask;
          ox_d    = $signed(CW'(radius));
          oy_d    = '0;
          crit_d  = CRW'(1) - $signed(CRW'(radius));
          k_d     = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (k_q == 3'd7) state_d = UPDATE;
        else             k_d = k_q + 3'd1;
      end
      UPDATE: begin
        // Midpoint step: both branches use the already-advanced oy (and ox)
        if (crit_q[CRW-1] || crit_q == '0) begin
          crit_d = crit_q + CRW'(oy_n) + CRW'(oy_n) + CRW'(1);
        end else begin
          ox_n   = ox_q - CW'(1);
          dif    = oy_n - ox_n;
          crit_d = crit_q + CRW'(dif) + CRW'(dif) + CRW'(1);
        end
        oy_d = oy_n;
        ox_d = ox_n;
        k_d  = '0;
        state_d = (oy_n <= ox_n) ? DRAW : END_DRAW;
      end
      END_DRAW: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Candidate pixel for the state being entered, so the registered strobe
  // and coordinates line up with the DRAW cycle they belong to.
  always_comb begin
    sx = $signed(CW'(cx_d));
    sy = $signed(CW'(cy_d));
    unique case (k_d)
      3'd0: begin cand_x = sx + ox_d; cand_y = sy + oy_d; end
      3'd1: begin cand_x = sx + oy_d; cand_y = sy + ox_d; end
      3'd2: begin cand_x = sx - oy_d; cand_y = sy + ox_d; end
      3'd3: begin cand_x = sx - ox_d; cand_y = sy + oy_d; end
      3'd4: begin cand_x = sx - ox_d; cand_y = sy - oy_d; end
      3'd5: begin cand_x = sx - oy_d; cand_y = sy - ox_d; end
      3'd6: begin cand_x = sx + oy_d; cand_y = sy - ox_d; end
      default: begin cand_x = sx + ox_d; cand_y = sy - oy_d; end
    endcase
    on_screen = !cand_x[CW-1] && (cand_x < SW_S) &&
                !cand_y[CW-1] && (cand_y < SH_S);
    plot_d    = (state_d == DRAW) && mask_d[k_d] && on_screen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      crit_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      col_q      <= '0;
      mask_q     <= '0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state      <= state_d;
      k_q        <= k_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      crit_q     <= crit_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      col_q      <= col_d;
      mask_q     <= mask_d;
      done       <= (state_d == END_DRAW);
      vga_plot   <= plot_d;
      vga_colour <= col_d;
      if (state_d == DRAW) begin
        vga_x <= cand_x[X_W-1:0];
        vga_y <= cand_y[Y_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_circle_octant_draw.sv
module tb_circle_octant_draw;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [2:0] colour = '0;
  logic [7:0] octant_mask = '0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  circle_octant_draw #(
    .X_W(8), .Y_W(7), .R_W(8), .COL_W(3), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .colour(colour), .octant_mask(octant_mask),
    .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int col; } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_draw = 0;
  int   n_upd  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every plot strobe
  always @(negedge clk) begin
    pix_t g;
    pix_t e;
    if (!rst) begin
      if (int'(dut.state) == 1) n_draw++;
      if (int'(dut.state) == 2) n_upd++;
      if (vga_plot) begin
        g.x = int'(vga_x);
        g.y = int'(vga_y);
        g.col = int'(vga_colour);
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("plot_x", g.x, e.x);
          chk("plot_y", g.y, e.y);
          chk("plot_colour", g.col, e.col);
        end
      end
    end
  end

  function automatic void push_pix(input int x, input int y, input int col);
    pix_t p;
    p.x = x; p.y = y; p.col = col;
    exp_q.push_back(p);
  endfunction

  // Reference midpoint circle; returns the iteration count
  function automatic int model(input int cx, input int cy, input int r,
                               input int col, input logic [7:0] m);
    int x, y, d, it;
    int px[8];
    int py[8];
    x = r; y = 0; d = 1 - r; it = 0;
    do begin
      it++;
      px = '{cx+x, cx+y, cx-y, cx-x, cx-x, cx-y, cx+y, cx+x};
      py = '{cy+y, cy+x, cy+x, cy+y, cy-y, cy-x, cy-x, cy-y};
      for (int k = 0; k < 8; k++)
        if (m[k] && px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120)
          push_pix(px[k], py[k], col);
      y++;
      if (d <= 0) d += 2*y + 1;
      else begin
        x--;
        d += 2*(y - x) + 1;
      end
    end while (y <= x);
    return it;
  endfunction

  task automatic run(input int cx, input int cy, input int r, input int col,
                     input logic [7:0] m, input int iters, input bit toggle,
                     input string tag);
    int d0, u0, nexp;
    bit seen;
    d0 = n_draw; u0 = n_upd; nexp = exp_q.size(); seen = 0;
    got_q.delete();
    @(posedge clk); #1;
    centre_x = cx[7:0]; centre_y = cy[6:0]; radius = r[7:0];
    colour = col[2:0]; octant_mask = m; start = 1'b1;
    if (toggle) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b0;
      radius = 8'd99;
      @(posedge clk); #1 start = 1'b1;
    end
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_draw_cycles"}, n_draw - d0, 8*iters);
    chk({tag, "_update_cycles"}, n_upd - u0, iters);
    chk({tag, "_state_end"}, int'(dut.state), 3);
    chk({tag, "_plot_in_end"}, int'(vga_plot), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_hold"}, int'(done), 1);
    chk({tag, "_state_hold"}, int'(dut.state), 3);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_state_idle"}, int'(dut.state), 0);
    chk({tag, "_done_low"}, int'(done), 0);
    chk({tag, "_plot_count"}, got_q.size(), nexp);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int it, bad, dx, dy, e;
    bit rseen;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", int'(dut.state), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);
    repeat (3) @(negedge clk);
    chk("rst_stay_idle", int'(dut.state), 0);

    // Radius 0: eight pulses at the centre
    for (int i = 0; i < 8; i++) push_pix(80, 60, 2);
    run(80, 60, 0, 2, 8'hFF, 1, 0, "r0");

    // Radius 1, octant 0 only
    push_pix(81, 60, 5);
    push_pix(81, 61, 5);
    run(80, 60, 1, 5, 8'h01, 2, 0, "r1");

    // Clipping at the origin
    it = model(0, 0, 10, 7, 8'hFF);
    run(0, 0, 10, 7, 8'hFF, it, 0, "clip");
    chk("clip_size_ge4", int'(got_q.size() >= 4), 1);
    if (got_q.size() >= 4) begin
      chk("clip_p0_x", got_q[0].x, 10); chk("clip_p0_y", got_q[0].y, 0);
      chk("clip_p1_x", got_q[1].x, 0);  chk("clip_p1_y", got_q[1].y, 10);
      chk("clip_p2_x", got_q[2].x, 0);  chk("clip_p2_y", got_q[2].y, 10);
      chk("clip_p3_x", got_q[3].x, 10); chk("clip_p3_y", got_q[3].y, 0);
    end

    // Radius 60: every plotted pixel near the ideal circle
    it = model(80, 60, 60, 1, 8'hFF);
    run(80, 60, 60, 1, 8'hFF, it, 0, "r60");
    bad = 0;
    foreach (got_q[i]) begin
      dx = got_q[i].x - 80;
      dy = got_q[i].y - 60;
      e = dx*dx + dy*dy - 3600;
      if (e > 120 || e < -120) bad++;
    end
    chk("r60_radius_error_pixels", bad, 0);
    chk("r60_nonempty", int'(got_q.size() > 0), 1);

    // Reset in the middle of DRAW
    void'(model(80, 60, 30, 4, 8'hFF));
    got_q.delete();
    @(posedge clk); #1;
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd30;
    colour = 3'd4; octant_mask = 8'hFF; start = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_in_draw", int'(dut.state), 1);
    @(posedge clk); #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", int'(dut.state), 0);
    chk("midrst_plot", int'(vga_plot), 0);
    chk("midrst_done", int'(done), 0);
    exp_q.delete();
    got_q.delete();
    repeat (5) @(negedge clk);
    chk("midrst_no_plots", got_q.size(), 0);

    // Fresh draw with a start toggle during DRAW (radius change ignored)
    it = model(80, 60, 30, 4, 8'hFF);
    run(80, 60, 30, 4, 8'hFF, it, 1, "r30_toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
